// File: rtl/core_pkg.sv
// Shared LSU definitions: FSM states, access sizes and RISC-V load/store funct3 encodings.
package core_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_CMD  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Any funct3 outside the defined load/store encodings falls back to a word access.
  function automatic lsu_size_e lsu_access_size(input logic [2:0] funct3, input logic is_store);
    lsu_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: picks the byte/halfword lane at off_i and sign- or zero-extends it.
module lsu_load_align
  import core_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;
  logic        sign_ext;

  assign lane     = raw_i >> {off_i, 3'b000};
  assign sign_ext = ~funct3_i[2];

  always_comb begin
    data_o = lane;
    case (lsu_access_size(funct3_i, 1'b0))
      SZ_BYTE: data_o = {{24{sign_ext & lane[7]}}, lane[7:0]};
      SZ_HALF: data_o = {{16{sign_ext & lane[15]}}, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit bridging the MEM stage to an Avalon-MM master port (IDLE/CMD/RESP/DONE).
// Optional macro LSU_MISALIGN_EXC_EN: flag and drop misaligned halfword/word accesses instead of issuing them.
module lsu
  import core_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    mem_opcode,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          lsu_stall,
  output logic          load_misaligned,
  output logic          store_misaligned,
  output logic          avn_read,
  output logic          avn_write,
  output logic [AW-1:0] avn_address,
  output logic [3:0]    avn_byte_enable,
  output logic [DW-1:0] avn_writedata,
  input  logic [DW-1:0] avn_readdata,
  input  logic          avn_waitrequest,
  input  logic          avn_readdatavalid
);

  lsu_state_e    state_q, state_d;
  logic [AW-3:0] addr_q;
  logic [1:0]    off_q;
  logic [2:0]    op_q;
  logic          store_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] raw_q;

  logic          req_store;
  logic          req_valid;
  logic          blocked;
  logic          accept;
  lsu_size_e     req_size;
  logic [1:0]    req_off;
  logic [3:0]    req_be;
  logic [DW-1:0] req_wdata;

  // A request with both mem_read and mem_write set is handled as a store.
  assign req_store = mem_write;
  assign req_valid = (mem_read | mem_write) & (state_q == LSU_IDLE);
  assign req_size  = lsu_access_size(mem_opcode, req_store);

`ifdef LSU_MISALIGN_EXC_EN
  logic misaligned;
  assign misaligned = ((req_size == SZ_HALF) & address[0]) |
                      ((req_size == SZ_WORD) & (address[1:0] != 2'b00));
  assign blocked          = misaligned;
  assign load_misaligned  = rst_b & req_valid & ~req_store & misaligned;
  assign store_misaligned = rst_b & req_valid &  req_store & misaligned;
`else
  assign blocked          = 1'b0;
  assign load_misaligned  = 1'b0;
  assign store_misaligned = 1'b0;
`endif

  assign accept = rst_b & req_valid & ~blocked;

  // Offset is the effective lane: halfwords drop addr[0], words drop addr[1:0].
  always_comb begin
    req_off   = 2'b00;
    req_be    = 4'b1111;
    req_wdata = wdata;
    case (req_size)
      SZ_BYTE: begin
        req_off   = address[1:0];
        req_be    = 4'b0001 << address[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        req_off   = {address[1], 1'b0};
        req_be    = 4'b0011 << {address[1], 1'b0};
        req_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = LSU_CMD;
      LSU_CMD:  if (!avn_waitrequest) state_d = store_q ? LSU_DONE : LSU_RESP;
      LSU_RESP: if (avn_readdatavalid) state_d = LSU_DONE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      op_q    <= '0;
      store_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= address[AW-1:2];
        off_q   <= req_off;
        op_q    <= mem_opcode;
        store_q <= req_store;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      // Read data is only taken once the command has been accepted.
      if ((state_q == LSU_RESP) && avn_readdatavalid) raw_q <= avn_readdata;
    end
  end

  assign avn_read        = (state_q == LSU_CMD) & ~store_q;
  assign avn_write       = (state_q == LSU_CMD) &  store_q;
  assign avn_address     = {addr_q, 2'b00};
  assign avn_byte_enable = be_q;
  assign avn_writedata   = wdata_q;
  assign lsu_stall       = (state_q == LSU_CMD) | (state_q == LSU_RESP) | accept;

  lsu_load_align u_load_align (
    .raw_i    (raw_q),
    .off_i    (off_q),
    .funct3_i (op_q),
    .data_o   (rdata)
  );

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver plays MEM stage and Avalon slave, the monitor checks bus, stall and load data.
`timescale 1ns/1ps
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_read, mem_write;
  logic [2:0]  mem_opcode;
  logic [31:0] address, wdata, rdata;
  logic        lsu_stall, load_misaligned, store_misaligned;
  logic        avn_read, avn_write;
  logic [31:0] avn_address;
  logic [3:0]  avn_byte_enable;
  logic [31:0] avn_writedata, avn_readdata;
  logic        avn_waitrequest, avn_readdatavalid;

  always #5 clk = ~clk;

  lsu #(.AW(32), .DW(32)) dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_opcode        (mem_opcode),
    .address           (address),
    .wdata             (wdata),
    .rdata             (rdata),
    .lsu_stall         (lsu_stall),
    .load_misaligned   (load_misaligned),
    .store_misaligned  (store_misaligned),
    .avn_read          (avn_read),
    .avn_write         (avn_write),
    .avn_address       (avn_address),
    .avn_byte_enable   (avn_byte_enable),
    .avn_writedata     (avn_writedata),
    .avn_readdata      (avn_readdata),
    .avn_waitrequest   (avn_waitrequest),
    .avn_readdatavalid (avn_readdatavalid)
  );

  typedef struct {
    bit          is_store;
    bit          aborted;
    logic [31:0] addr_w;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    int          bus_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference rules: access width in bytes from funct3.
  function automatic int size_of(input bit st, input logic [2:0] op);
    if (st) return (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avn_read"},  32'(avn_read), 32'd0);
    check({tag, "_avn_write"}, 32'(avn_write), 32'd0);
    check({tag, "_avn_addr"},  avn_address, 32'd0);
    check({tag, "_avn_be"},    32'(avn_byte_enable), 32'd0);
    check({tag, "_avn_wdata"}, avn_writedata, 32'd0);
    check({tag, "_rdata"},     rdata, 32'd0);
    check({tag, "_stall"},     32'(lsu_stall), 32'd0);
    check({tag, "_ld_mis"},    32'(load_misaligned), 32'd0);
    check({tag, "_st_mis"},    32'(store_misaligned), 32'd0);
  endtask

  // Monitor: compares bus cycles against the head entry, and closes the entry when lsu_stall falls.
  initial begin : monitor
    int   stall_cnt;
    int   bus_cnt;
    exp_t e;
    stall_cnt = 0;
    bus_cnt   = 0;
    forever begin
      @(negedge clk);
      if (avn_read || avn_write) begin
        bus_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bus: actual rd=%0b wr=%0b addr=0x%08h required no access",
                   avn_read, avn_write, avn_address);
        end else begin
          e = exp_q[0];
          check("bus_read",  32'(avn_read),  32'(!e.is_store));
          check("bus_write", 32'(avn_write), 32'(e.is_store));
          check("bus_addr",  avn_address, e.addr_w);
          check("bus_be",    32'(avn_byte_enable), 32'(e.be));
          if (e.is_store) check("bus_wdata", avn_writedata, e.wd);
        end
      end
      if (lsu_stall) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_stall: actual %0d stall cycles required none", stall_cnt);
        end else begin
          e = exp_q.pop_front();
          if (!e.aborted) begin
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            check("bus_cycles",   32'(bus_cnt),   32'(e.bus_cycles));
            if (!e.is_store) check("load_rdata", rdata, e.rd);
          end
        end
        stall_cnt = 0;
        bus_cnt   = 0;
      end
    end
  end

  task automatic run_txn(input bit st, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] bus_rd,
                         input int nwait, input int rdelay, input bit do_reset);
    exp_t        e;
    int          sz, lo, off;
    bit          mis;
    logic [31:0] mask, v;
    sz  = size_of(st, op);
    lo  = int'(addr[1:0]);
    off = lo - (lo % sz);
    mis = (lo % sz) != 0;
    @(posedge clk); #1;
    mem_read   = ~st;
    mem_write  = st;
    mem_opcode = op;
    address    = addr;
    wdata      = wd;
    #1;
`ifdef LSU_MISALIGN_EXC_EN
    if (mis) begin
      check("mis_load_flag",  32'(load_misaligned),  32'(!st));
      check("mis_store_flag", 32'(store_misaligned), 32'(st));
      check("mis_stall",      32'(lsu_stall), 32'd0);
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      $display("txn %0d: %s f3=%0d addr=0x%08h misaligned, trapped", n_txn, st ? "ST" : "LD", op, addr);
      n_txn++;
      return;
    end
`endif
    check("load_flag",  32'(load_misaligned),  32'd0);
    check("store_flag", 32'(store_misaligned), 32'd0);

    mask = (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    v    = (bus_rd >> (8 * off)) & mask;
    if (!st && (op == 3'd0 || op == 3'd1) && v[8*sz-1]) v = v | ~mask;
    e.is_store   = st;
    e.aborted    = do_reset;
    e.addr_w     = addr & 32'hFFFF_FFFC;
    e.be         = 4'(((1 << sz) - 1) << off);
    e.wd         = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                   (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    e.rd         = v;
    e.stall      = st ? 2 + nwait : 3 + nwait + rdelay;
    e.bus_cycles = nwait + 1;
    exp_q.push_back(e);

    avn_waitrequest = (nwait > 0);
    @(posedge clk); #1;
    for (int i = 0; i < nwait; i++) begin
      // Stray readdatavalid while the command is still pending must be ignored.
      avn_readdatavalid = 1'b1;
      avn_readdata      = $urandom;
      @(posedge clk); #1;
    end
    avn_waitrequest   = 1'b0;
    avn_readdatavalid = 1'b0;
    @(posedge clk); #1;
    if (!st) begin
      if (do_reset) begin
        #2 rst_b = 1'b0;
        #1 check_reset_outputs("midrst");
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        $display("txn %0d: LD f3=%0d addr=0x%08h reset during response", n_txn, op, addr);
        n_txn++;
        return;
      end
      for (int i = 0; i < rdelay; i++) begin
        @(posedge clk); #1;
      end
      avn_readdatavalid = 1'b1;
      avn_readdata      = bus_rd;
      @(posedge clk); #1;
      avn_readdatavalid = 1'b0;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    $display("txn %0d: %s f3=%0d addr=0x%08h wd=0x%08h bus_rd=0x%08h wait=%0d rdly=%0d mis=%0b exp_rd=0x%08h",
             n_txn, st ? "ST" : "LD", op, addr, wd, bus_rd, nwait, rdelay, mis, e.rd);
    n_txn++;
  endtask

  initial begin : main
    bit          st;
    logic [2:0]  op;
    logic [31:0] addr, wd, brd;
    int          nw, rd;
    rst_b = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_opcode = 3'd0; address = '0; wdata = '0;
    avn_readdata = '0; avn_waitrequest = 1'b0; avn_readdatavalid = 1'b0;
    #1 rst_b = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    run_txn(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 0, 0, 1'b0);
    run_txn(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 0, 0, 1'b0);
    run_txn(1'b1, 3'd1, 32'h0000_0202, 32'h0000_1234, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 5, 0, 1'b0);
    run_txn(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0);
    run_txn(1'b0, 3'd5, 32'h0000_0012, 32'h0, 32'h9ABC_5678, 1, 2, 1'b0);
    run_txn(1'b0, 3'd1, 32'h0000_0012, 32'h0, 32'h9ABC_5678, 0, 1, 1'b0);
    run_txn(1'b1, 3'd0, 32'h0000_0041, 32'h0000_00A5, 32'h0, 2, 0, 1'b0);
    run_txn(1'b0, 3'd7, 32'h0000_0020, 32'h0, 32'h8765_4321, 0, 0, 1'b0);
    run_txn(1'b0, 3'd2, 32'h0000_0400, 32'h0, 32'h1111_2222, 1, 3, 1'b1);
    run_txn(1'b1, 3'd2, 32'h0000_0104, 32'h0BAD_CAFE, 32'h0, 0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      st   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      wd   = $urandom;
      brd  = $urandom;
      nw   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 2);
      run_txn(st, op, addr, wd, brd, nw, rd, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter AW, default 32, meaning bus address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (only 32 supported).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b  input  1  the reset, asynchronous and active-low.
REQ-005 SHALL have port mem_read  input  1  MEM-stage instruction is a load.
REQ-006 SHALL have port mem_write  input  1  MEM-stage instruction is a store.
REQ-007 SHALL have port mem_opcode  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port address  input  AW  effective byte address.
REQ-009 SHALL have port wdata  input  DW  store data in rs2 format.
REQ-010 SHALL have port rdata  output  DW  extended load result, valid in DONE.
REQ-011 SHALL have port lsu_stall  output  1  stall request to the hazard unit.
REQ-012 SHALL have port load_misaligned / store_misaligned  output  1 each  misalignment flags.
REQ-013 SHALL have ports avn_read, avn_write (out 1), avn_address (out AW), avn_byte_enable (out 4), avn_writedata (out DW), avn_readdata (in DW), avn_waitrequest (in 1), avn_readdatavalid (in 1).

Function
REQ-014 SHALL implement FSM IDLE, CMD, RESP, DONE.
REQ-015 IDLE: aligned mem_read|mem_write -> CMD, latch address/opcode/byte enable/data; else stay.
REQ-016 CMD: drive avn_read or avn_write; hold all bus outputs stable while avn_waitrequest=1.
REQ-017 CMD with avn_waitrequest=0: store -> DONE, load -> RESP.
REQ-018 RESP: avn_readdatavalid=1 -> capture avn_readdata -> DONE; otherwise wait indefinitely.
REQ-019 DONE: -> IDLE unconditionally; rdata valid this cycle only.
REQ-020 lsu_stall SHALL be 1 in CMD and RESP, and in IDLE when an aligned access is presented; 0 in DONE and otherwise.
REQ-021 Minimum stall: store 2 cycles, load 3 cycles (zero-wait bus).
REQ-022 avn_address SHALL be the latched address with bits [1:0] cleared.
REQ-023 Byte enable: SB 4'b0001<<addr[1:0]; SH 4'b0011<<(2*addr[1]); SW 4'b1111.
REQ-024 avn_writedata: SB replicates byte x4, SH replicates halfword x2, SW passes through.
REQ-025 rdata: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by latched addr[1:0]; LW passes through.
REQ-026 Undefined funct3 SHALL be treated as word access.
REQ-027 A response with avn_readdatavalid in CMD (before acceptance) SHALL be ignored.

Reset
REQ-028 rst_b low SHALL force IDLE immediately, including mid-transaction.
REQ-029 Reset values: avn_read=0, avn_write=0, avn_address=0, avn_byte_enable=0, avn_writedata=0, rdata=0, lsu_stall=0, misaligned flags=0.

Configuration
REQ-030 With macro LSU_MISALIGN_EXC_EN defined: in IDLE, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL assert the matching flag combinationally, issue no bus access, keep lsu_stall=0, and remain in IDLE.
REQ-031 Without LSU_MISALIGN_EXC_EN: flags SHALL be tied 0; halfword accesses ignore addr[0]; word accesses ignore addr[1:0].

Structure
REQ-032 FSM state enum and funct3 load/store constants SHALL live in shared package core_pkg.
REQ-033 Load lane extraction and extension SHALL be sub-module lsu_load_align (combinational).

Verification
REQ-034 SW addr 0x100, data 0xDEADBEEF, waitrequest 0 -> avn_write one cycle, be=4'b1111, lsu_stall high exactly 2 cycles.
REQ-035 LB addr 0x103, readdata 0x80FF_FF12, readdatavalid one cycle after acceptance -> rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-036 SH addr 0x202, wdata 0x1234 -> be=4'b1100, writedata=0x12341234, avn_address=0x200.
REQ-037 LW with waitrequest high 5 cycles -> bus outputs stable throughout, lsu_stall high for 5+3 cycles.
REQ-038 LW addr 0x101 with LSU_MISALIGN_EXC_EN -> load_misaligned=1, no avn_read, lsu_stall=0; without the macro -> read at 0x100, flag 0.
REQ-039 rst_b low during RESP -> outputs at reset values asynchronously; after release, a new SW completes normally.
